// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite GPIO register block: one GPIO channel (data + per-bit tristate) behind a small register map.
// Optional interrupt logic (GIER/IPISR/IPIER, ip2intc_irpt) is built only when GPIO_INTR_EN is defined.
module axi_lite_gpio_slave #(
    parameter int          C_S_AXI_ADDR_WIDTH = 9,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_GPIO_WIDTH       = 32,
    parameter logic [31:0] C_DOUT_DEFAULT     = 32'h0000_0000,
    parameter logic [31:0] C_TRI_DEFAULT      = 32'hFFFF_FFFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    input  logic [C_GPIO_WIDTH-1:0]           gpio_in,
    output logic [C_GPIO_WIDTH-1:0]           gpio_out,
    output logic [C_GPIO_WIDTH-1:0]           gpio_tri
`ifdef GPIO_INTR_EN
    ,
    output logic                              ip2intc_irpt
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int GW = C_GPIO_WIDTH;

    localparam logic [6:0] WORD_DATA  = 7'h00;
    localparam logic [6:0] WORD_TRI   = 7'h01;
    localparam logic [6:0] WORD_GIER  = 7'h47;
    localparam logic [6:0] WORD_IPISR = 7'h48;
    localparam logic [6:0] WORD_IPIER = 7'h4A;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a beat transfers on any rising edge where valid && ready are both high.
    // The ready/valid outputs here are all registered; a ready drops on its own handshake and
    // rises again only when the matching response (B or R) has been accepted.
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [6:0]    aw_word_q, aw_word_d;
    logic [6:0]    ar_word_q, ar_word_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [GW-1:0] data_q, data_d;
    logic [GW-1:0] tri_q, tri_d;
    logic [GW-1:0] sync1_q, sync1_d;
    logic [GW-1:0] sync2_q, sync2_d;
`ifdef GPIO_INTR_EN
    logic [GW-1:0] prev_q, prev_d;
    logic          gier_q, gier_d;
    logic          ipier_q, ipier_d;
    logic          ipisr_q, ipisr_d;
    logic          irpt_q, irpt_d;
    logic          in_change;
    logic          isr_clear;
`endif

    logic          aw_hs, w_hs, ar_hs;
    logic          wr_commit, rd_capture, b_done, r_done;
    logic [DW-1:0] data_ext, tri_ext, pins_ext, merged_data, merged_tri, rd_val;
    logic [GW-1:0] pin_val;
    logic          unused_addr_bits;

    // Address bits [1:0] select a byte within the word and carry no meaning here.
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic word_mapped(input logic [6:0] w);
        logic hit;
        hit = (w == WORD_DATA) || (w == WORD_TRI);
`ifdef GPIO_INTR_EN
        hit = hit || (w == WORD_GIER) || (w == WORD_IPISR) || (w == WORD_IPIER);
`endif
        return hit;
    endfunction

    always_comb begin
        data_ext            = '0;
        data_ext[GW-1:0]    = data_q;
        tri_ext             = '0;
        tri_ext[GW-1:0]     = tri_q;
        // Input pins report the synchronized level; output pins report what we drive.
        pin_val             = (tri_q & sync2_q) | (~tri_q & data_q);
        pins_ext            = '0;
        pins_ext[GW-1:0]    = pin_val;
        merged_data         = merge_bytes(data_ext, wdata_q, wstrb_q);
        merged_tri          = merge_bytes(tri_ext, wdata_q, wstrb_q);
    end

    always_comb begin
        rd_val = '0;
        case (ar_word_q)
            WORD_DATA:  rd_val = pins_ext;
            WORD_TRI:   rd_val = tri_ext;
`ifdef GPIO_INTR_EN
            WORD_GIER:  rd_val[31] = gier_q;
            WORD_IPISR: rd_val[0]  = ipisr_q;
            WORD_IPIER: rd_val[0]  = ipier_q;
`endif
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        aw_word_d = aw_word_q;
        ar_word_d = ar_word_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        tri_d     = tri_q;
        sync1_d   = gpio_in;
        sync2_d   = sync1_q;

        aw_hs      = s_axi_awvalid && awready_q;
        w_hs       = s_axi_wvalid && wready_q;
        ar_hs      = s_axi_arvalid && arready_q;
        wr_commit  = !awready_q && !wready_q && !bvalid_q;
        rd_capture = !arready_q && !rvalid_q;
        b_done     = bvalid_q && s_axi_bready;
        r_done     = rvalid_q && s_axi_rready;

        if (aw_hs) begin
            awready_d = 1'b0;
            aw_word_d = s_axi_awaddr[8:2];
        end
        if (w_hs) begin
            wready_d = 1'b0;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        // Both payloads are held and no response is pending: perform the write now.
        if (wr_commit) begin
            bvalid_d = 1'b1;
            bresp_d  = word_mapped(aw_word_q) ? RESP_OKAY : RESP_SLVERR;
            case (aw_word_q)
                WORD_DATA: data_d = merged_data[GW-1:0];
                WORD_TRI:  tri_d  = merged_tri[GW-1:0];
                default:   ;
            endcase
        end
        if (b_done) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end

        if (ar_hs) begin
            arready_d = 1'b0;
            ar_word_d = s_axi_araddr[8:2];
        end
        // Captured from register state before this edge, so a coincident write is not seen.
        if (rd_capture) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = word_mapped(ar_word_q) ? RESP_OKAY : RESP_SLVERR;
        end
        if (r_done) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end
    end

`ifdef GPIO_INTR_EN
    always_comb begin
        gier_d    = gier_q;
        ipier_d   = ipier_q;
        prev_d    = sync2_q;
        in_change = |((sync2_q ^ prev_q) & tri_q);
        isr_clear = wr_commit && (aw_word_q == WORD_IPISR) && wstrb_q[0] && wdata_q[0];
        if (wr_commit && (aw_word_q == WORD_GIER) && wstrb_q[3]) begin
            gier_d = wdata_q[31];
        end
        if (wr_commit && (aw_word_q == WORD_IPIER) && wstrb_q[0]) begin
            ipier_d = wdata_q[0];
        end
        // A new input event in the clear cycle keeps the status bit set.
        ipisr_d = (ipisr_q && !isr_clear) || in_change;
        irpt_d  = gier_q && ipier_q && ipisr_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            aw_word_q <= '0;
            ar_word_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            data_q    <= C_DOUT_DEFAULT[GW-1:0];
            tri_q     <= C_TRI_DEFAULT[GW-1:0];
            sync1_q   <= '0;
            sync2_q   <= '0;
`ifdef GPIO_INTR_EN
            prev_q    <= '0;
            gier_q    <= 1'b0;
            ipier_q   <= 1'b0;
            ipisr_q   <= 1'b0;
            irpt_q    <= 1'b0;
`endif
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            aw_word_q <= aw_word_d;
            ar_word_q <= ar_word_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            data_q    <= data_d;
            tri_q     <= tri_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
`ifdef GPIO_INTR_EN
            prev_q    <= prev_d;
            gier_q    <= gier_d;
            ipier_q   <= ipier_d;
            ipisr_q   <= ipisr_d;
            irpt_q    <= irpt_d;
`endif
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign gpio_out      = data_q;
    assign gpio_tri      = tri_q;
`ifdef GPIO_INTR_EN
    assign ip2intc_irpt  = irpt_q;
`endif

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// Directed + randomized bench for axi_lite_gpio_slave; a register-map model predicts every read and write.
// Interrupt steps are compiled in only when GPIO_INTR_EN is defined.
module tb_axi_lite_gpio_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [8:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_tri;
`ifdef GPIO_INTR_EN
    logic        irpt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_data;
    logic [31:0] m_tri;
    logic        m_gier;
    logic        m_ipier;

    axi_lite_gpio_slave dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_tri      (gpio_tri)
`ifdef GPIO_INTR_EN
        ,
        .ip2intc_irpt  (irpt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mask = mask | (32'hFF << (8 * b));
        end
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic model_mapped(input logic [8:0] a);
        logic [8:0] w;
        w = a & 9'h1FC;
`ifdef GPIO_INTR_EN
        return (w == 9'h000) || (w == 9'h004) || (w == 9'h11C) || (w == 9'h120) || (w == 9'h128);
`else
        return (w == 9'h000) || (w == 9'h004);
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [8:0] a);
        logic [8:0] w;
        w = a & 9'h1FC;
        if (w == 9'h000) return (m_tri & gpio_in) | (~m_tri & m_data);
        if (w == 9'h004) return m_tri;
`ifdef GPIO_INTR_EN
        if (w == 9'h11C) return m_gier ? 32'h8000_0000 : 32'h0;
        if (w == 9'h128) return m_ipier ? 32'h1 : 32'h0;
`endif
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [8:0] w;
        w = a & 9'h1FC;
        if (w == 9'h000) m_data = merge(m_data, d, strb);
        if (w == 9'h004) m_tri = merge(m_tri, d, strb);
`ifdef GPIO_INTR_EN
        if (w == 9'h11C && strb[3]) m_gier = d[31];
        if (w == 9'h128 && strb[0]) m_ipier = d[0];
`endif
    endfunction

    function automatic void model_reset();
        m_data  = 32'h0;
        m_tri   = 32'hFFFF_FFFF;
        m_gier  = 1'b0;
        m_ipier = 1'b0;
    endfunction

    function automatic logic [8:0] pick_addr();
        logic [8:0] base;
        case ($urandom_range(0, 5))
            0:       base = 9'h000;
            1:       base = 9'h004;
            2:       base = 9'h11C;
            3:       base = 9'h128;
            4:       base = 9'h040;
            default: base = 9'h1FC;
        endcase
        return base | 9'($urandom_range(0, 3));
    endfunction

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_fire, w_fire, aw_done, w_done;
        int cyc, n;
        aw_fire = 0; w_fire = 0; aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 60) begin
            @(negedge clk);
            if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && !s_axi_awvalid && cyc >= aw_dly) begin
                s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
            end
            if (!w_done && !s_axi_wvalid && cyc >= w_dly) begin
                s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb;
            end
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            cyc++;
        end
        check("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
        n = 0;
        while (!s_axi_bvalid && n < 10) begin @(negedge clk); n++; end
        check("b_latency", 32'(n), 32'd1);
        resp = s_axi_bresp;
        repeat (b_dly) begin
            @(negedge clk);
            check("b_hold", 32'({s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_bresp == resp}), 32'b1001);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_release", 32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'b011);
    endtask

    task automatic axi_read(input logic [8:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
        check("ar_ready_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("ar_drop", 32'({s_axi_arready, s_axi_rvalid}), 32'b00);
        n = 0;
        while (!s_axi_rvalid && n < 10) begin @(negedge clk); n++; end
        check("r_latency", 32'(n), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        repeat (r_dly) begin
            @(negedge clk);
            check("r_hold", 32'({s_axi_rvalid, s_axi_arready}), 32'b10);
            check("r_data_stable", s_axi_rdata, data);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("r_release", 32'({s_axi_rvalid, s_axi_arready}), 32'b01);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  bs;
    logic [8:0]  ra;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          n;

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        gpio_in = 32'h1234_5678;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'b111);
        check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'b00);
        check("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_gpio_tri", gpio_tri, 32'hFFFF_FFFF);
`ifdef GPIO_INTR_EN
        check("rst_irpt", 32'(irpt), 32'h0);
`endif

        axi_read(9'h004, 0, rd, rs);
        check("rd_tri_reset", rd, 32'hFFFF_FFFF);
        check("rd_tri_resp", 32'(rs), 32'h0);
        axi_read(9'h000, 0, rd, rs);
        check("rd_data_pins", rd, 32'h1234_5678);

        // all pins to outputs, then W leads AW by 3 cycles
        axi_write(9'h004, 32'h0, 4'hF, 0, 0, 0, bs);
        model_write(9'h004, 32'h0, 4'hF);
        check("wr_tri_resp", 32'(bs), 32'h0);
        check("gpio_tri_out", gpio_tri, 32'h0);
        axi_write(9'h000, 32'hA5A5_0F0F, 4'hF, 3, 0, 1, bs);
        model_write(9'h000, 32'hA5A5_0F0F, 4'hF);
        check("wr_data_resp", 32'(bs), 32'h0);
        check("gpio_out_full", gpio_out, 32'hA5A5_0F0F);
        axi_read(9'h000, 0, rd, rs);
        check("rd_back_full", rd, 32'hA5A5_0F0F);

        // single-byte strobe
        axi_write(9'h000, 32'h0, 4'hF, 0, 0, 0, bs);
        model_write(9'h000, 32'h0, 4'hF);
        axi_write(9'h000, 32'hFFFF_FFFF, 4'h2, 1, 0, 0, bs);
        model_write(9'h000, 32'hFFFF_FFFF, 4'h2);
        check("gpio_out_byte1", gpio_out, 32'h0000_FF00);

        // zero strobe leaves the register alone
        axi_write(9'h000, 32'h1357_9BDF, 4'h0, 0, 2, 0, bs);
        check("wstrb0_resp", 32'(bs), 32'h0);
        check("wstrb0_out", gpio_out, 32'h0000_FF00);

        // stalled read
        axi_read(9'h000, 4, rd, rs);
        check("rd_stall_data", rd, 32'h0000_FF00);

        // unmapped address
        axi_write(9'h040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, bs);
        check("wr_unmapped_resp", 32'(bs), 32'h2);
        axi_read(9'h040, 0, rd, rs);
        check("rd_unmapped_resp", 32'(rs), 32'h2);
        check("rd_unmapped_data", rd, 32'h0);
        check("unmapped_no_change", gpio_out, 32'h0000_FF00);
        check("unmapped_no_change_tri", gpio_tri, 32'h0);

        // write and read of GPIO_DATA resolving on the same edge: read sees the old value
        @(negedge clk);
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h2222_2222; s_axi_wstrb = 4'hF;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 9'h000;
        s_axi_arvalid = 1'b1; s_axi_araddr = 9'h000;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("same_edge_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'b11);
        check("same_edge_rdata", s_axi_rdata, 32'h0000_FF00);
        check("same_edge_gpio_out", gpio_out, 32'h2222_2222);
        model_write(9'h000, 32'h2222_2222, 4'hF);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("same_edge_release", 32'({s_axi_bvalid, s_axi_rvalid}), 32'b00);

        // reset in the middle of a write: only AW has been accepted
        @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 9'h000;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("mid_aw_taken", 32'(s_axi_awready), 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_awready", 32'(s_axi_awready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_b", 32'(s_axi_bvalid), 32'h0);
        end
        check("mid_rst_gpio_out", gpio_out, 32'h0);
        check("mid_rst_gpio_tri", gpio_tri, 32'hFFFF_FFFF);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            gpio_in = $urandom;
            repeat (4) @(negedge clk);
            ra = pick_addr();
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
                axi_write(ra, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), bs);
                check("rand_bresp", 32'(bs), model_mapped(ra) ? 32'h0 : 32'h2);
                if (model_mapped(ra)) model_write(ra, wd, ws);
                check("rand_gpio_out", gpio_out, m_data);
                check("rand_gpio_tri", gpio_tri, m_tri);
            end else begin
                axi_read(ra, $urandom_range(0, 2), rd, rs);
                check("rand_rresp", 32'(rs), model_mapped(ra) ? 32'h0 : 32'h2);
                check("rand_rdata", rd, model_read(ra));
            end
        end

`ifdef GPIO_INTR_EN
        // interrupt on an input-pin change, cleared by writing 1 to IPISR
        axi_write(9'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, bs);
        axi_write(9'h11C, 32'h8000_0000, 4'hF, 0, 0, 0, bs);
        axi_write(9'h128, 32'h1, 4'hF, 0, 0, 0, bs);
        repeat (4) @(negedge clk);
        axi_write(9'h120, 32'h1, 4'hF, 0, 0, 0, bs);
        check("isr_clear_resp", 32'(bs), 32'h0);
        repeat (3) @(negedge clk);
        check("irpt_idle", 32'(irpt), 32'h0);
        gpio_in = gpio_in ^ 32'h1;
        n = 0;
        while (!irpt && n < 8) begin @(negedge clk); n++; end
        check("irpt_rise_in_4", 32'(irpt && n <= 4), 32'h1);
        axi_read(9'h120, 0, rd, rs);
        check("isr_set_read", rd, 32'h1);
        axi_write(9'h120, 32'h1, 4'h1, 0, 0, 0, bs);
        @(negedge clk);
        check("irpt_cleared", 32'(irpt), 32'h0);
        axi_read(9'h120, 0, rd, rs);
        check("isr_cleared_read", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_gpio_slave.md
Name: axi_lite_gpio_slave

Overview:
AXI4-Lite slave register block: the DUT that consumes the AXI4-Lite bus driven by the verification environment's AXI interface. It decodes writes and reads to a small GPIO register map and drives one GPIO channel (data out, per-bit tristate). It samples GPIO inputs through a synchronizer and returns them on reads.

Parameters:
C_S_AXI_ADDR_WIDTH, 9, byte address width of the AXI4-Lite port
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported
C_GPIO_WIDTH, 32, number of GPIO bits (1..32)
C_DOUT_DEFAULT, 0, reset value of GPIO_DATA output register
C_TRI_DEFAULT, all ones, reset value of GPIO_TRI (1 = input)

Ports:
clk  in  1  bus and core clock
rst  in  1  asynchronous, active-high reset
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data
s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
gpio_in  in  C_GPIO_WIDTH  asynchronous GPIO inputs
gpio_out  out  C_GPIO_WIDTH  GPIO_DATA output register
gpio_tri  out  C_GPIO_WIDTH  GPIO_TRI register (1 = pin is input)
ip2intc_irpt  out  1  interrupt (present only with GPIO_INTR_EN)

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, gpio_out=C_DOUT_DEFAULT, gpio_tri=C_TRI_DEFAULT, irpt=0.
- Reset mid-transaction aborts it; no response is issued afterwards.
- Register map (addr[8:2] decoded, addr[1:0] ignored):
  - 0x000 GPIO_DATA: RW
  - 0x004 GPIO_TRI: RW
  - 0x11C GIER: bit31 only
  - 0x120 IPISR: bit0, W1C
  - 0x128 IPIER: bit0
  - Bits above C_GPIO_WIDTH read 0.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle.
  - On its handshake, each channel latches its payload and drops its ready.
  - The cycle after both are held: the register is updated byte-wise per wstrb, and bvalid=1 with bresp.
  - bvalid holds until bready. On the bvalid&&bready cycle, bvalid=0 and awready=wready=1 again.
  - Only one write is outstanding at a time.
- Read path:
  - On the arvalid&&arready cycle: arready=0.
  - Next cycle: rvalid=1, with rdata/rresp captured at that edge.
  - rdata/rresp hold stable until rready. Then rvalid=0 and arready=1.
  - Read latency is 1 cycle from handshake.
- GPIO_DATA read value, per bit: tri=1 → synchronized gpio_in; tri=0 → gpio_out.
- gpio_in passes through a 2-flop synchronizer, so a pin change is visible on reads 2–3 cycles later.
- Unmapped address:
  - Write: ignored, bresp=2'b10 (SLVERR).
  - Read: rdata=0, rresp=2'b10.
- A mapped access returns 2'b00 (OKAY).
- Read and write to the same register landing on the same edge: the read returns the pre-write value.
- Write with wstrb=0: no register change, OKAY response.

Optional Feature:
GPIO_INTR_EN defined:
- IPISR[0] sets on any change of the synchronized input bits whose GPIO_TRI=1.
- IPISR[0] is cleared by writing 1. A set event in the clear cycle wins.
- ip2intc_irpt = GIER[31] & IPIER[0] & IPISR[0], registered.

Undefined:
- GIER, IPISR and IPIER are unmapped (SLVERR).
- No ip2intc_irpt port.

Test Plan:
- Reset, then read 0x004 → rdata=0xFFFF_FFFF, OKAY. Read 0x000 with gpio_in=0x1234_5678 → 0x1234_5678.
- Write TRI=0, then DATA=0xA5A5_0F0F with wstrb=0xF, W presented 3 cycles before AW → gpio_out=0xA5A5_0F0F. bvalid is asserted 1 cycle after the AW handshake; read-back matches.
- DATA=0, then write 0xFFFF_FFFF with wstrb=0x2 → gpio_out=0x0000_FF00.
- Read 0x000 with rready held low 4 cycles → rvalid stays 1, rdata stable, arready=0 throughout; released on the rready cycle.
- Write and read 0x040 → bresp=2'b10; rresp=2'b10, rdata=0. No register changes.
- GPIO_INTR_EN: GIER=0x8000_0000, IPIER=1, gpio_in bit0 toggles → irpt=1 within 4 cycles. Write 1 to 0x120 → irpt=0.
